// File: rtl/io_command_queue.sv
// Command queue between the issue stage and the GPIO controller: a DEPTH-entry
// FIFO with its head driving REQ/ACK, plus a one-entry register for read-back responses.
module io_command_queue #(
   parameter int DEPTH          = 4,
   parameter int DATA_WIDTH     = 16,
   parameter int REG_ADDR_WIDTH = 4
) (
   input  logic                         clk,
   input  logic                         async_rst_n,
   input  logic                         clk_en,
   input  logic                         Flush,
   input  logic                         Cmd_Valid,
   output logic                         Cmd_Ready,
   input  logic                         Cmd_ResponseRequested,
   input  logic [REG_ADDR_WIDTH-1:0]    Cmd_DestReg,
   input  logic [DATA_WIDTH-1:0]        Cmd_Data,
   output logic                         Ctl_REQ,
   input  logic                         Ctl_ACK,
   output logic                         Ctl_CommandEn,
   output logic                         Ctl_ResponseRequested,
   output logic [REG_ADDR_WIDTH-1:0]    Ctl_DestReg,
   output logic [DATA_WIDTH-1:0]        Ctl_Data,
   input  logic                         Ctl_RegResponseFlag,
   input  logic [REG_ADDR_WIDTH-1:0]    Ctl_DestRegRet,
   input  logic [DATA_WIDTH-1:0]        Ctl_DataRet,
   output logic                         Rsp_Valid,
   input  logic                         Rsp_Ready,
   output logic [REG_ADDR_WIDTH-1:0]    Rsp_DestReg,
   output logic [DATA_WIDTH-1:0]        Rsp_Data,
   output logic [$clog2(DEPTH+1)-1:0]   Queue_Count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH+1);

   // Handshakes: a transfer happens on a clk_en cycle where valid (or REQ) and
   // ready (or ACK) are both high; valid/REQ never depend on ready/ACK.

   logic [PTR_W-1:0]          r_wr_ptr;
   logic [PTR_W-1:0]          r_rd_ptr;
   logic [CNT_W-1:0]          r_count;
   logic                      r_mem_rr   [DEPTH];
   logic [REG_ADDR_WIDTH-1:0] r_mem_tag  [DEPTH];
   logic [DATA_WIDTH-1:0]     r_mem_data [DEPTH];

   logic                      r_rsp_valid;
   logic [REG_ADDR_WIDTH-1:0] r_rsp_tag;
   logic [DATA_WIDTH-1:0]     r_rsp_data;

   logic w_empty;
   logic w_full;
   logic w_head_rr;
   logic w_stall;
   logic w_req;
   logic w_push;
   logic w_pop;
   logic w_rsp_drain;

   assign w_empty   = (r_count == '0);
   assign w_full    = (r_count == CNT_W'(DEPTH));
   assign w_head_rr = !w_empty && r_mem_rr[r_rd_ptr];

   // Held conservatively for any response-requesting head, read or not.
   assign w_stall = w_head_rr && r_rsp_valid && !Rsp_Ready;
   assign w_req   = !w_empty && !w_stall && !Flush;

   assign Cmd_Ready     = !w_full && !Flush;
   assign Ctl_REQ       = w_req;
   assign Ctl_CommandEn = w_req;

   assign Ctl_ResponseRequested = w_head_rr;
   assign Ctl_DestReg           = w_empty ? '0 : r_mem_tag[r_rd_ptr];
   assign Ctl_Data              = w_empty ? '0 : r_mem_data[r_rd_ptr];

   assign w_push      = Cmd_Valid && Cmd_Ready && clk_en;
   assign w_pop       = w_req && Ctl_ACK && clk_en;
   assign w_rsp_drain = r_rsp_valid && Rsp_Ready && clk_en;

   assign Rsp_Valid   = r_rsp_valid;
   assign Rsp_DestReg = r_rsp_tag;
   assign Rsp_Data    = r_rsp_data;
   assign Queue_Count = r_count;

   // Storage needs no reset; the count gates every read of it.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem_rr[r_wr_ptr]   <= Cmd_ResponseRequested;
         r_mem_tag[r_wr_ptr]  <= Cmd_DestReg;
         r_mem_data[r_wr_ptr] <= Cmd_Data;
      end
   end

   always_ff @(posedge clk or negedge async_rst_n) begin
      if (!async_rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (clk_en) begin
         if (Flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
         end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            unique case ({w_push, w_pop})
               2'b10:   r_count <= r_count + CNT_W'(1);
               2'b01:   r_count <= r_count - CNT_W'(1);
               default: r_count <= r_count;
            endcase
         end
      end
   end

   // Capture wins over drain, so a same-cycle drain and capture keeps valid high.
   always_ff @(posedge clk or negedge async_rst_n) begin
      if (!async_rst_n) begin
         r_rsp_valid <= 1'b0;
         r_rsp_tag   <= '0;
         r_rsp_data  <= '0;
      end else if (w_pop && Ctl_RegResponseFlag) begin
         r_rsp_valid <= 1'b1;
         r_rsp_tag   <= Ctl_DestRegRet;
         r_rsp_data  <= Ctl_DataRet;
      end else if (w_rsp_drain) begin
         r_rsp_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_io_command_queue.sv
// Directed bench for io_command_queue: hand-computed expectations for fill,
// backpressure, response capture/stall, wrap, flush, clock enable and reset.
module tb_io_command_queue;

   logic        clk = 1'b0;
   logic        async_rst_n;
   logic        clk_en;
   logic        Flush;
   logic        Cmd_Valid;
   logic        Cmd_Ready;
   logic        Cmd_ResponseRequested;
   logic [3:0]  Cmd_DestReg;
   logic [15:0] Cmd_Data;
   logic        Ctl_REQ;
   logic        Ctl_ACK;
   logic        Ctl_CommandEn;
   logic        Ctl_ResponseRequested;
   logic [3:0]  Ctl_DestReg;
   logic [15:0] Ctl_Data;
   logic        Ctl_RegResponseFlag;
   logic [3:0]  Ctl_DestRegRet;
   logic [15:0] Ctl_DataRet;
   logic        Rsp_Valid;
   logic        Rsp_Ready;
   logic [3:0]  Rsp_DestReg;
   logic [15:0] Rsp_Data;
   logic [2:0]  Queue_Count;

   int n_vec = 0;
   int n_err = 0;
   logic [15:0] exp_q[$];

   io_command_queue #(.DEPTH(4), .DATA_WIDTH(16), .REG_ADDR_WIDTH(4)) dut (
      .clk(clk), .async_rst_n(async_rst_n), .clk_en(clk_en), .Flush(Flush),
      .Cmd_Valid(Cmd_Valid), .Cmd_Ready(Cmd_Ready),
      .Cmd_ResponseRequested(Cmd_ResponseRequested), .Cmd_DestReg(Cmd_DestReg),
      .Cmd_Data(Cmd_Data), .Ctl_REQ(Ctl_REQ), .Ctl_ACK(Ctl_ACK),
      .Ctl_CommandEn(Ctl_CommandEn), .Ctl_ResponseRequested(Ctl_ResponseRequested),
      .Ctl_DestReg(Ctl_DestReg), .Ctl_Data(Ctl_Data),
      .Ctl_RegResponseFlag(Ctl_RegResponseFlag), .Ctl_DestRegRet(Ctl_DestRegRet),
      .Ctl_DataRet(Ctl_DataRet), .Rsp_Valid(Rsp_Valid), .Rsp_Ready(Rsp_Ready),
      .Rsp_DestReg(Rsp_DestReg), .Rsp_Data(Rsp_Data), .Queue_Count(Queue_Count)
   );

   // clock / reset
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
      end
   endtask

   // advance one clock; inputs change and outputs are sampled 1ns after the edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic push(input logic rr, input logic [3:0] tag, input logic [15:0] data);
      Cmd_Valid = 1'b1; Cmd_ResponseRequested = rr; Cmd_DestReg = tag; Cmd_Data = data;
      step();
      Cmd_Valid = 1'b0; Cmd_ResponseRequested = 1'b0;
      settle();
   endtask

   // pop the head while checking its data
   task automatic pop_chk(input string tag, input logic [15:0] exp);
      Ctl_ACK = 1'b1;
      settle();
      chk(tag, Ctl_Data, exp);
      step();
      Ctl_ACK = 1'b0;
      settle();
   endtask

   initial begin
      async_rst_n = 1'b0; clk_en = 1'b1; Flush = 1'b0;
      Cmd_Valid = 1'b0; Cmd_ResponseRequested = 1'b0; Cmd_DestReg = '0; Cmd_Data = '0;
      Ctl_ACK = 1'b0; Ctl_RegResponseFlag = 1'b0; Ctl_DestRegRet = '0; Ctl_DataRet = '0;
      Rsp_Ready = 1'b0;
      repeat (3) step();
      async_rst_n = 1'b1;
      settle();
      chk("rst_ready", Cmd_Ready, 1);
      chk("rst_req", Ctl_REQ, 0);
      chk("rst_count", Queue_Count, 0);
      chk("rst_rsp_valid", Rsp_Valid, 0);
      chk("rst_ctl_data", Ctl_Data, 0);

      // single command, no response
      push(1'b0, 4'd3, 16'h2001);
      chk("t1_req", Ctl_REQ, 1);
      chk("t1_cmden", Ctl_CommandEn, 1);
      chk("t1_data", Ctl_Data, 16'h2001);
      chk("t1_tag", Ctl_DestReg, 3);
      chk("t1_count", Queue_Count, 1);
      pop_chk("t1_pop", 16'h2001);
      chk("t1_count0", Queue_Count, 0);
      chk("t1_rsp", Rsp_Valid, 0);

      // fill to DEPTH, 5th waits for a pop
      for (int i = 1; i <= 4; i++) push(1'b0, 4'(i), 16'(i));
      chk("t2_count4", Queue_Count, 4);
      chk("t2_full_ready", Cmd_Ready, 0);
      Cmd_Valid = 1'b1; Cmd_Data = 16'd5; Cmd_DestReg = 4'd5;
      step();
      chk("t2_no_push", Queue_Count, 4);
      Ctl_ACK = 1'b1;
      settle();
      chk("t2_pop_ready", Cmd_Ready, 0);
      chk("t2_head1", Ctl_Data, 16'd1);
      step();
      Ctl_ACK = 1'b0;
      settle();
      chk("t2_count3", Queue_Count, 3);
      chk("t2_ready_after", Cmd_Ready, 1);
      step();
      Cmd_Valid = 1'b0;
      settle();
      chk("t2_count4b", Queue_Count, 4);
      for (int i = 2; i <= 5; i++) pop_chk("t2_order", 16'(i));
      chk("t2_empty", Queue_Count, 0);

      // read command with response capture
      push(1'b1, 4'd7, 16'h6C00);
      chk("t3_rr", Ctl_ResponseRequested, 1);
      Ctl_RegResponseFlag = 1'b1; Ctl_DestRegRet = 4'd7; Ctl_DataRet = 16'h00A5;
      pop_chk("t3_head", 16'h6C00);
      Ctl_RegResponseFlag = 1'b0;
      chk("t3_rsp_valid", Rsp_Valid, 1);
      chk("t3_rsp_tag", Rsp_DestReg, 7);
      chk("t3_rsp_data", Rsp_Data, 16'h00A5);

      // stall behind an undrained response
      push(1'b1, 4'd2, 16'h6C01);
      chk("t4_stall_req", Ctl_REQ, 0);
      Ctl_ACK = 1'b1; Ctl_RegResponseFlag = 1'b1; Ctl_DestRegRet = 4'd1; Ctl_DataRet = 16'h1111;
      step();
      chk("t4_stall_count", Queue_Count, 1);
      chk("t4_flag_ignored", Rsp_Data, 16'h00A5);
      Rsp_Ready = 1'b1; Ctl_DestRegRet = 4'd2; Ctl_DataRet = 16'h5A5A;
      settle();
      chk("t4_req_release", Ctl_REQ, 1);
      step();
      Ctl_ACK = 1'b0; Ctl_RegResponseFlag = 1'b0;
      settle();
      chk("t4_replace_valid", Rsp_Valid, 1);
      chk("t4_replace_tag", Rsp_DestReg, 2);
      chk("t4_replace_data", Rsp_Data, 16'h5A5A);
      chk("t4_count0", Queue_Count, 0);
      step();
      chk("t4_drained", Rsp_Valid, 0);
      Rsp_Ready = 1'b0;

      // simultaneous push/pop at count=1 and count=DEPTH-1
      push(1'b0, 4'd0, 16'hA000);
      Cmd_Valid = 1'b1; Cmd_Data = 16'hB000;
      pop_chk("t5_c1_head", 16'hA000);
      Cmd_Valid = 1'b0;
      chk("t5_c1_count", Queue_Count, 1);
      chk("t5_c1_next", Ctl_Data, 16'hB000);
      push(1'b0, 4'd0, 16'hC000);
      push(1'b0, 4'd0, 16'hD000);
      Cmd_Valid = 1'b1; Cmd_Data = 16'hE000;
      pop_chk("t5_c3_head", 16'hB000);
      Cmd_Valid = 1'b0;
      chk("t5_c3_count", Queue_Count, 3);
      pop_chk("t5_drain", 16'hC000);
      pop_chk("t5_drain", 16'hD000);
      pop_chk("t5_drain", 16'hE000);

      // 3*DEPTH streaming transfers to wrap the pointers
      push(1'b0, 4'd0, 16'h0100);
      exp_q.push_back(16'h0100);
      for (int i = 1; i < 12; i++) begin
         Cmd_Valid = 1'b1; Cmd_Data = 16'h0100 + 16'(i);
         pop_chk("t5_wrap", exp_q.pop_front());
         exp_q.push_back(16'h0100 + 16'(i));
         chk("t5_wrap_count", Queue_Count, 1);
      end
      Cmd_Valid = 1'b0;
      pop_chk("t5_wrap_last", exp_q.pop_front());
      chk("t5_wrap_empty", Queue_Count, 0);

      // flush with 3 entries and a held response
      push(1'b1, 4'd9, 16'h6C02);
      Ctl_RegResponseFlag = 1'b1; Ctl_DestRegRet = 4'd9; Ctl_DataRet = 16'h0BEE;
      pop_chk("t6_rd", 16'h6C02);
      Ctl_RegResponseFlag = 1'b0;
      for (int i = 0; i < 3; i++) push(1'b0, 4'd0, 16'h3000 + 16'(i));
      chk("t6_count3", Queue_Count, 3);
      Flush = 1'b1; Cmd_Valid = 1'b1; Ctl_ACK = 1'b1;
      settle();
      chk("t6_flush_ready", Cmd_Ready, 0);
      chk("t6_flush_req", Ctl_REQ, 0);
      step();
      Flush = 1'b0; Cmd_Valid = 1'b0; Ctl_ACK = 1'b0;
      settle();
      chk("t6_flush_count", Queue_Count, 0);
      chk("t6_rsp_kept", Rsp_Valid, 1);
      chk("t6_rsp_data", Rsp_Data, 16'h0BEE);

      // clock enable low freezes everything
      clk_en = 1'b0; Cmd_Valid = 1'b1; Cmd_Data = 16'h4444; Rsp_Ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         chk("t6_clken_count", Queue_Count, 0);
         chk("t6_clken_rsp", Rsp_Valid, 1);
      end
      clk_en = 1'b1;
      step();
      Cmd_Valid = 1'b0; Rsp_Ready = 1'b0;
      settle();
      chk("t6_en_count", Queue_Count, 1);
      chk("t6_en_head", Ctl_Data, 16'h4444);
      chk("t6_en_drain", Rsp_Valid, 0);

      // asynchronous reset mid-operation, held response present
      push(1'b0, 4'd0, 16'h5555);
      push(1'b1, 4'd4, 16'h6C03);
      pop_chk("t7_pre", 16'h4444);
      pop_chk("t7_pre", 16'h5555);
      Ctl_RegResponseFlag = 1'b1; Ctl_DataRet = 16'h7777;
      pop_chk("t7_pre", 16'h6C03);
      Ctl_RegResponseFlag = 1'b0;
      push(1'b0, 4'd0, 16'h8888);
      chk("t7_pre_rsp", Rsp_Valid, 1);
      #3;
      async_rst_n = 1'b0;
      #1;
      chk("t7_rst_count", Queue_Count, 0);
      chk("t7_rst_rsp", Rsp_Valid, 0);
      chk("t7_rst_req", Ctl_REQ, 0);
      chk("t7_rst_rsp_data", Rsp_Data, 0);
      step();
      async_rst_n = 1'b1;
      settle();
      chk("t7_ready", Cmd_Ready, 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
